// File: rtl/edge_detection.sv
// Edge detector: turns a synchronous level signal into a one-cycle strobe on a
// rising edge, a falling edge or both, depending on the parameters.
module edge_detection #(
  parameter bit RISING_EDGE  = 1'b1,
  parameter bit FALLING_EDGE = 1'b0,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  logic in_q;
  logic rise;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= RESET_LEVEL;
    end else begin
      in_q <= in;
    end
  end

  // Strobe is combinational from the live input; rst_n gates it because in
  // may already differ from the reloaded history while reset is held.
  always_comb begin
    rise = in & ~in_q;
    fall = ~in & in_q;
    out  = rst_n & ((RISING_EDGE & rise) | (FALLING_EDGE & fall));
  end

  a_quiet_in_reset : assert property (@(posedge clk) !rst_n |-> !out);

  a_out_needs_change : assert property (@(posedge clk) out |-> (in != in_q));

  a_rise_only_no_fall : assert property (@(posedge clk) disable iff (!rst_n)
    (RISING_EDGE && !FALLING_EDGE && out) |-> in);

  a_known_out : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(in) |-> !$isunknown(out));

endmodule

// File: tb/tb_edge_detection.sv
// Directed bench for edge_detection: five parameter variants share one
// stimulus stream; expected strobes are hand-computed per step.
module tb_edge_detection;

  logic clk;
  logic rst_n;
  logic in;
  logic o_r0, o_f0, o_b0, o_n0, o_f1;
  logic [4:0] outs;

  int checks;
  int errors;

  // r0: rising, f0: falling, b0: both, n0: none, f1: falling with RESET_LEVEL=1
  edge_detection #(.RISING_EDGE(1'b1), .FALLING_EDGE(1'b0), .RESET_LEVEL(1'b0))
    u_r0 (.clk(clk), .rst_n(rst_n), .in(in), .out(o_r0));
  edge_detection #(.RISING_EDGE(1'b0), .FALLING_EDGE(1'b1), .RESET_LEVEL(1'b0))
    u_f0 (.clk(clk), .rst_n(rst_n), .in(in), .out(o_f0));
  edge_detection #(.RISING_EDGE(1'b1), .FALLING_EDGE(1'b1), .RESET_LEVEL(1'b0))
    u_b0 (.clk(clk), .rst_n(rst_n), .in(in), .out(o_b0));
  edge_detection #(.RISING_EDGE(1'b0), .FALLING_EDGE(1'b0), .RESET_LEVEL(1'b0))
    u_n0 (.clk(clk), .rst_n(rst_n), .in(in), .out(o_n0));
  edge_detection #(.RISING_EDGE(1'b0), .FALLING_EDGE(1'b1), .RESET_LEVEL(1'b1))
    u_f1 (.clk(clk), .rst_n(rst_n), .in(in), .out(o_f1));

  assign outs = {o_r0, o_f0, o_b0, o_n0, o_f1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       in;
    logic [4:0] exp;   // {r0, f0, b0, n0, f1}
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int pulses_r;
    int pulses_f;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in     = 1'b0;

    vec[0]  = '{1'b0, 1'b0, 5'b00000};  // in reset
    vec[1]  = '{1'b0, 1'b1, 5'b00000};  // in differs but reset forces 0
    vec[2]  = '{1'b1, 1'b0, 5'b00001};  // release: f1 history=1, in=0 -> fall
    vec[3]  = '{1'b1, 1'b0, 5'b00000};
    vec[4]  = '{1'b1, 1'b1, 5'b10100};  // rising edge
    vec[5]  = '{1'b1, 1'b1, 5'b00000};  // held
    vec[6]  = '{1'b1, 1'b0, 5'b01101};  // falling edge
    vec[7]  = '{1'b1, 1'b0, 5'b00000};
    vec[8]  = '{1'b1, 1'b1, 5'b10100};  // toggle every cycle x4
    vec[9]  = '{1'b1, 1'b0, 5'b01101};
    vec[10] = '{1'b1, 1'b1, 5'b10100};
    vec[11] = '{1'b1, 1'b0, 5'b01101};
    vec[12] = '{1'b1, 1'b0, 5'b00000};  // held again
    vec[13] = '{1'b1, 1'b0, 5'b00000};
    vec[14] = '{1'b1, 1'b1, 5'b10100};  // pulse starts
    vec[15] = '{1'b0, 1'b1, 5'b00000};  // reset mid-pulse
    vec[16] = '{1'b1, 1'b1, 5'b10100};  // release with in=1, RESET_LEVEL=0
    vec[17] = '{1'b1, 1'b1, 5'b00000};

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #2;
      rst_n = vec[i].rst_n;
      in    = vec[i].in;
      #2;
      checks++;
      if (outs !== vec[i].exp) begin
        errors++;
        $display("FAIL vec%0d: outs=%b expected %b", i, outs, vec[i].exp);
      end
    end

    // Reset asserted while a pulse is visible: strobe drops within the cycle.
    @(posedge clk); #2; in = 1'b0;
    @(posedge clk); #2; in = 1'b1;
    #1 check1("pulse_before_reset", o_r0, 1'b1);
    rst_n = 1'b0;
    #1 check1("pulse_killed_by_reset", o_r0, 1'b0);
    check1("both_killed_by_reset", o_b0, 1'b0);
    @(posedge clk); #2; rst_n = 1'b1;
    #1 check1("rise_after_release", o_r0, 1'b1);
    @(posedge clk); #2;
    check1("rise_after_release_ends", o_r0, 1'b0);

    // Stable input: one rising edge then in held high for 20 cycles.
    in = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    pulses_r = 0;
    pulses_f = 0;
    in = 1'b1;
    for (int c = 0; c < 21; c++) begin
      #2;
      if (o_r0 === 1'b1) pulses_r++;
      if (o_f0 === 1'b1) pulses_f++;
      @(posedge clk); #2;
    end
    checks++;
    if (pulses_r != 1) begin
      errors++;
      $display("FAIL stable_rise_count: got %0d expected 1", pulses_r);
    end
    checks++;
    if (pulses_f != 0) begin
      errors++;
      $display("FAIL stable_fall_count: got %0d expected 0", pulses_f);
    end

    // Both edges disabled: random input never produces a strobe.
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      in = 1'($urandom_range(0, 1));
      #2 check1("none_mode_quiet", o_n0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
